// File: rtl/mmio_wait_controller.sv
// FPro MMIO slot controller: per-slot strobes, ready/wait handshake with timeout,
// bus error for unpopulated or stalled slots, and a built-in statistics slot.
module mmio_wait_controller #(
  parameter int unsigned N_SLOT    = 64,
  parameter int unsigned REG_AW    = 5,
  parameter logic [63:0] SLOT_MASK = 64'h0000_0000_0000_050F,
  parameter int unsigned TIMEOUT   = 16,
  parameter int unsigned STAT_SLOT = N_SLOT - 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   mmio_cs,
  input  logic                   mmio_wr,
  input  logic                   mmio_rd,
  input  logic [20:0]            mmio_addr,
  input  logic [31:0]            mmio_wr_data,
  output logic [31:0]            mmio_rd_data,
  output logic                   mmio_ready,
  output logic                   mmio_err,
  output logic [N_SLOT-1:0]      slot_cs_array,
  output logic [N_SLOT-1:0]      slot_mem_rd_array,
  output logic [N_SLOT-1:0]      slot_mem_wr_array,
  output logic [REG_AW-1:0]      slot_reg_addr,
  output logic [31:0]            slot_wr_data,
  input  logic [N_SLOT*32-1:0]   slot_rd_data_flat,
  input  logic [N_SLOT-1:0]      slot_ready_array
);
  localparam int unsigned SW = $clog2(N_SLOT);
  localparam int unsigned AW = 21;
  localparam logic [N_SLOT-1:0] POP = SLOT_MASK[N_SLOT-1:0];
  localparam logic [SW-1:0] STAT = SW'(STAT_SLOT);
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, ACCESS, WAIT, DONE} state_t;

  state_t              state_q, state_d;
  logic [SW-1:0]       slot_q, slot_d;
  logic [REG_AW-1:0]   reg_q, reg_d;
  logic [31:0]         wdata_q, wdata_d;
  logic                wr_q, wr_d;
  logic [7:0]          cnt_q, cnt_d;
  logic [N_SLOT-1:0]   cs_q, cs_d, rd_stb_q, rd_stb_d, wr_stb_q, wr_stb_d;
  logic                ready_q, ready_d, err_q, err_d;
  logic [31:0]         rdata_q, rdata_d;
  logic [15:0]         err_cnt_q, err_cnt_d;
  logic                err_type_q, err_type_d;
  logic [5:0]          err_slot_q, err_slot_d;
  logic [1:0]          err_reg_q, err_reg_d;
  logic [31:0]         acc_cnt_q, acc_cnt_d;

  logic [SW-1:0]       op_slot;
  logic [REG_AW-1:0]   op_reg;
  logic                op_wr;
  logic                finish, fail, fail_type;
  logic [N_SLOT-1:0]   sel;
  logic [31:0]         rd_word [N_SLOT];
  logic                unused_addr_bits;

  assign unused_addr_bits = ^mmio_addr[AW-1:REG_AW+SW];

  for (genvar i = 0; i < int'(N_SLOT); i++) begin : g_rd_word
    assign rd_word[i] = slot_rd_data_flat[32*i +: 32];
  end

  // Next-state and next-output logic; completion bookkeeping is shared via finish/fail.
  always_comb begin
    state_d    = state_q;
    slot_d     = slot_q;
    reg_d      = reg_q;
    wdata_d    = wdata_q;
    wr_d       = wr_q;
    cnt_d      = cnt_q;
    cs_d       = '0;
    rd_stb_d   = '0;
    wr_stb_d   = '0;
    ready_d    = 1'b0;
    err_d      = 1'b0;
    rdata_d    = rdata_q;
    err_cnt_d  = err_cnt_q;
    err_type_d = err_type_q;
    err_slot_d = err_slot_q;
    err_reg_d  = err_reg_q;
    acc_cnt_d  = acc_cnt_q;
    op_slot    = slot_q;
    op_reg     = reg_q;
    op_wr      = wr_q;
    finish     = 1'b0;
    fail       = 1'b0;
    fail_type  = 1'b0;
    sel        = '0;

    case (state_q)
      IDLE: begin
        if (mmio_cs && (mmio_rd || mmio_wr)) begin
          op_slot = mmio_addr[REG_AW +: SW];
          op_reg  = mmio_addr[REG_AW-1:0];
          op_wr   = mmio_wr;
          slot_d  = op_slot;
          reg_d   = op_reg;
          wdata_d = mmio_wr_data;
          wr_d    = op_wr;
          if (op_slot == STAT) begin
            state_d = DONE;
            ready_d = 1'b1;
            if (op_wr) begin
              rdata_d = '0;
              if (op_reg == REG_AW'(0)) begin
                err_cnt_d  = '0;
                err_type_d = 1'b0;
                err_slot_d = '0;
                err_reg_d  = '0;
              end else if (op_reg == REG_AW'(2)) begin
                acc_cnt_d = '0;
              end
            end else if (op_reg == REG_AW'(0)) begin
              rdata_d = {16'h0, err_cnt_q};
            end else if (op_reg == REG_AW'(1)) begin
              rdata_d = {23'h0, err_type_q, err_slot_q, err_reg_q};
            end else if (op_reg == REG_AW'(2)) begin
              rdata_d = acc_cnt_q;
            end else begin
              rdata_d = '0;
            end
          end else if (!POP[op_slot]) begin
            finish = 1'b1;
            fail   = 1'b1;
          end else begin
            state_d = ACCESS;
            sel     = N_SLOT'(1) << op_slot;
            cs_d    = sel;
            if (op_wr) wr_stb_d = sel;
            else       rd_stb_d = sel;
          end
        end
      end
      ACCESS: begin
        cnt_d = '0;
        if (slot_ready_array[slot_q]) finish = 1'b1;
        else                          state_d = WAIT;
      end
      WAIT: begin
        if (slot_ready_array[slot_q]) begin
          finish = 1'b1;
        end else if (cnt_q == TO_LAST) begin
          finish    = 1'b1;
          fail      = 1'b1;
          fail_type = 1'b1;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (finish) begin
      state_d   = DONE;
      ready_d   = 1'b1;
      err_d     = fail;
      rdata_d   = op_wr ? 32'h0 : (fail ? 32'hFFFF_FFFF : rd_word[op_slot]);
      acc_cnt_d = acc_cnt_q + 32'd1;
      if (fail) begin
        if (err_cnt_q != 16'hFFFF) err_cnt_d = err_cnt_q + 16'd1;
        err_type_d = fail_type;
        err_slot_d = 6'(op_slot);
        err_reg_d  = 2'(op_reg);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      slot_q     <= '0;
      reg_q      <= '0;
      wdata_q    <= '0;
      wr_q       <= 1'b0;
      cnt_q      <= '0;
      cs_q       <= '0;
      rd_stb_q   <= '0;
      wr_stb_q   <= '0;
      ready_q    <= 1'b0;
      err_q      <= 1'b0;
      rdata_q    <= '0;
      err_cnt_q  <= '0;
      err_type_q <= 1'b0;
      err_slot_q <= '0;
      err_reg_q  <= '0;
      acc_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      slot_q     <= slot_d;
      reg_q      <= reg_d;
      wdata_q    <= wdata_d;
      wr_q       <= wr_d;
      cnt_q      <= cnt_d;
      cs_q       <= cs_d;
      rd_stb_q   <= rd_stb_d;
      wr_stb_q   <= wr_stb_d;
      ready_q    <= ready_d;
      err_q      <= err_d;
      rdata_q    <= rdata_d;
      err_cnt_q  <= err_cnt_d;
      err_type_q <= err_type_d;
      err_slot_q <= err_slot_d;
      err_reg_q  <= err_reg_d;
      acc_cnt_q  <= acc_cnt_d;
    end
  end

  assign mmio_rd_data      = rdata_q;
  assign mmio_ready        = ready_q;
  assign mmio_err          = err_q;
  assign slot_cs_array     = cs_q;
  assign slot_mem_rd_array = rd_stb_q;
  assign slot_mem_wr_array = wr_stb_q;
  assign slot_reg_addr     = reg_q;
  assign slot_wr_data      = wdata_q;
endmodule

// File: tb/tb_mmio_wait_controller.sv
// Scoreboard bench for mmio_wait_controller: expected completions are queued at
// request time and matched (data, err, latency) when mmio_ready pulses.
module tb_mmio_wait_controller;
  localparam int N = 64;

  logic          clk = 1'b0;
  logic          reset;
  logic          mmio_cs, mmio_wr, mmio_rd;
  logic [20:0]   mmio_addr;
  logic [31:0]   mmio_wr_data, mmio_rd_data;
  logic          mmio_ready, mmio_err;
  logic [N-1:0]  slot_cs_array, slot_mem_rd_array, slot_mem_wr_array;
  logic [4:0]    slot_reg_addr;
  logic [31:0]   slot_wr_data;
  logic [N*32-1:0] slot_rd_data_flat;
  logic [N-1:0]  slot_ready_array;

  mmio_wait_controller dut (
    .clk(clk), .reset(reset),
    .mmio_cs(mmio_cs), .mmio_wr(mmio_wr), .mmio_rd(mmio_rd),
    .mmio_addr(mmio_addr), .mmio_wr_data(mmio_wr_data), .mmio_rd_data(mmio_rd_data),
    .mmio_ready(mmio_ready), .mmio_err(mmio_err),
    .slot_cs_array(slot_cs_array), .slot_mem_rd_array(slot_mem_rd_array),
    .slot_mem_wr_array(slot_mem_wr_array), .slot_reg_addr(slot_reg_addr),
    .slot_wr_data(slot_wr_data), .slot_rd_data_flat(slot_rd_data_flat),
    .slot_ready_array(slot_ready_array)
  );

  always #5 clk = ~clk;

  typedef struct { string tag; logic [31:0] data; logic err; int lat; } exp_t;
  typedef struct { int off; logic [63:0] cs; logic [63:0] rd; logic [63:0] wr; } stb_t;

  exp_t        exp_q[$];
  stb_t        stb_log[$];
  int          n_checks = 0, n_errors = 0;
  int          cyc = 0, req_cyc = 0, n_done = 0, done_mark = 0;
  logic [31:0] sdata [N];
  logic [N-1:0] tie, pulse;
  int          wslot = 0, wk = -1, wcount = -1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  always_comb begin
    for (int i = 0; i < N; i++) slot_rd_data_flat[32*i +: 32] = sdata[i];
  end
  assign slot_ready_array = tie | pulse;

  always @(posedge clk) cyc++;

  // Slot responder: raises ready for slot wslot exactly wk cycles after its strobe.
  always @(negedge clk) begin
    if (!reset) wcount = -1;
    else if (slot_cs_array[wslot]) wcount = 0;
    else if (wcount >= 0) wcount++;
    pulse = '0;
    if (wk >= 0 && wcount == wk) pulse[wslot] = 1'b1;
  end

  // Completion monitor and strobe log.
  always @(negedge clk) begin
    exp_t e;
    if (reset && (|slot_cs_array || |slot_mem_rd_array || |slot_mem_wr_array))
      stb_log.push_back('{cyc - req_cyc, slot_cs_array, slot_mem_rd_array, slot_mem_wr_array});
    if (reset && mmio_ready) begin
      if (exp_q.size() == 0) begin
        check("spurious_ready", 64'(mmio_ready), 64'd0);
      end else begin
        e = exp_q.pop_front();
        check({e.tag, "_data"}, 64'(mmio_rd_data), 64'(e.data));
        check({e.tag, "_err"}, 64'(mmio_err), 64'(e.err));
        check({e.tag, "_latency"}, 64'(cyc - req_cyc), 64'(e.lat));
      end
      n_done++;
    end
  end

  task automatic config_slot(input int s, input int k);
    tie[s] = 1'b0;
    wslot  = s;
    wk     = k;
  endtask

  task automatic release_slot(input int s);
    tie[s] = 1'b1;
    wk     = -1;
  endtask

  task automatic issue(input logic wr, input int slot, input int rg, input logic [31:0] wdata,
                       input logic [31:0] edata, input logic eerr, input int elat,
                       input string tag);
    exp_t e;
    @(posedge clk); #1;
    mmio_cs      = 1'b1;
    mmio_wr      = wr;
    mmio_rd      = !wr;
    mmio_addr    = 21'((slot << 5) | rg);
    mmio_wr_data = wdata;
    req_cyc      = cyc;
    done_mark    = n_done;
    stb_log.delete();
    e.tag = tag; e.data = edata; e.err = eerr; e.lat = elat;
    exp_q.push_back(e);
    @(posedge clk); #1;
    mmio_cs = 1'b0;
    mmio_rd = 1'b0;
    mmio_wr = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int k = 0;
    while (n_done == done_mark && k < 40) begin
      @(negedge clk); #1;
      k++;
    end
    check({tag, "_completed"}, 64'(n_done != done_mark), 64'd1);
  endtask

  task automatic check_strobes(input string tag, input int exp_n, input logic [63:0] ecs,
                               input logic [63:0] erd, input logic [63:0] ewr);
    check({tag, "_stb_count"}, 64'(stb_log.size()), 64'(exp_n));
    if (stb_log.size() > 0) begin
      check({tag, "_stb_cycle"}, 64'(stb_log[0].off), 64'd1);
      check({tag, "_stb_cs"}, stb_log[0].cs, ecs);
      check({tag, "_stb_rd"}, stb_log[0].rd, erd);
      check({tag, "_stb_wr"}, stb_log[0].wr, ewr);
    end
  endtask

  task automatic stat_rd(input int rg, input logic [31:0] exp, input string tag);
    issue(1'b0, 63, rg, 32'h0, exp, 1'b0, 1, tag);
    wait_done(tag);
  endtask

  task automatic stat_wr(input int rg, input string tag);
    issue(1'b1, 63, rg, 32'hDEAD_BEEF, 32'h0, 1'b0, 1, tag);
    wait_done(tag);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, checks %0d", n_checks);
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b0;
    mmio_cs = 1'b0; mmio_rd = 1'b0; mmio_wr = 1'b0;
    mmio_addr = '0; mmio_wr_data = '0;
    tie = '1;
    for (int i = 0; i < N; i++) sdata[i] = 32'hD000_0000 + 32'(i);
    sdata[2]  = 32'h0000_00A5;
    sdata[10] = 32'hCAFE_000A;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_ready", 64'(mmio_ready), 64'd0);
    check("reset_err", 64'(mmio_err), 64'd0);
    check("reset_rd_data", 64'(mmio_rd_data), 64'd0);
    check("reset_strobes", slot_cs_array | slot_mem_rd_array | slot_mem_wr_array, 64'd0);
    check("reset_latched", {27'h0, slot_reg_addr, slot_wr_data}, 64'd0);
    @(posedge clk); #1;
    reset = 1'b1;

    // Zero-wait read.
    issue(1'b0, 2, 0, 32'h0, 32'h0000_00A5, 1'b0, 2, "rd_s2");
    wait_done("rd_s2");
    check_strobes("rd_s2", 1, 64'd1 << 2, 64'd1 << 2, 64'd0);

    // Write with three wait cycles; latched address and data must stay put.
    config_slot(8, 3);
    issue(1'b1, 8, 3, 32'h1234_5678, 32'h0, 1'b0, 5, "wr_s8");
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      check("wr_s8_reg_addr", 64'(slot_reg_addr), 64'd3);
      check("wr_s8_wr_data", 64'(slot_wr_data), 64'h1234_5678);
    end
    wait_done("wr_s8");
    check_strobes("wr_s8", 1, 64'd1 << 8, 64'd0, 64'd1 << 8);
    release_slot(8);

    // Unpopulated slot.
    issue(1'b0, 5, 2, 32'h0, 32'hFFFF_FFFF, 1'b1, 1, "rd_s5_unpop");
    wait_done("rd_s5_unpop");
    check_strobes("rd_s5_unpop", 0, 64'd0, 64'd0, 64'd0);
    stat_rd(0, 32'd1, "stat_errcnt_1");
    stat_rd(1, 32'd22, "stat_last_unpop");
    stat_rd(2, 32'd3, "stat_acc_3");

    // Timeout, then ready arriving on the last allowed cycle.
    config_slot(10, -1);
    issue(1'b0, 10, 1, 32'h0, 32'hFFFF_FFFF, 1'b1, 18, "rd_s10_timeout");
    wait_done("rd_s10_timeout");
    check_strobes("rd_s10_timeout", 1, 64'd1 << 10, 64'd1 << 10, 64'd0);
    stat_rd(1, 32'd297, "stat_last_timeout");
    stat_rd(0, 32'd2, "stat_errcnt_2");
    config_slot(10, 16);
    issue(1'b0, 10, 1, 32'h0, 32'hCAFE_000A, 1'b0, 18, "rd_s10_late");
    wait_done("rd_s10_late");
    release_slot(10);
    stat_rd(2, 32'd5, "stat_acc_5");

    // Clear statistics, then three accesses with a stray request during WAIT.
    stat_wr(2, "clr_acc");
    stat_wr(0, "clr_err");
    stat_rd(2, 32'd0, "stat_acc_cleared");
    stat_rd(0, 32'd0, "stat_errcnt_cleared");
    stat_rd(1, 32'd0, "stat_last_cleared");
    stat_rd(7, 32'd0, "stat_reg7");
    issue(1'b0, 0, 4, 32'h0, 32'hD000_0000, 1'b0, 2, "rd_s0");
    wait_done("rd_s0");
    issue(1'b1, 1, 0, 32'h0000_0055, 32'h0, 1'b0, 2, "wr_s1");
    wait_done("wr_s1");
    config_slot(8, 5);
    issue(1'b0, 8, 2, 32'h0, 32'hD000_0008, 1'b0, 7, "rd_s8_wait");
    @(posedge clk); #1;
    mmio_cs = 1'b1; mmio_rd = 1'b1; mmio_addr = 21'(3 << 5);
    @(posedge clk); #1;
    mmio_cs = 1'b0; mmio_rd = 1'b0;
    wait_done("rd_s8_wait");
    check_strobes("rd_s8_wait", 1, 64'd1 << 8, 64'd1 << 8, 64'd0);
    release_slot(8);
    stat_rd(2, 32'd3, "stat_acc_3b");
    stat_wr(2, "clr_acc_b");
    stat_rd(2, 32'd0, "stat_acc_cleared_b");

    // Leave some statistics behind, then reset in the middle of a wait.
    issue(1'b0, 5, 0, 32'h0, 32'hFFFF_FFFF, 1'b1, 1, "rd_s5_again");
    wait_done("rd_s5_again");
    config_slot(10, -1);
    issue(1'b0, 10, 0, 32'h0, 32'h0, 1'b0, 0, "rst_abort");
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("rst_ready", 64'(mmio_ready), 64'd0);
    check("rst_strobes", slot_cs_array | slot_mem_rd_array | slot_mem_wr_array, 64'd0);
    check("rst_rd_data", 64'(mmio_rd_data), 64'd0);
    exp_q.delete();
    repeat (3) begin
      @(negedge clk);
      check("rst_hold_ready", 64'(mmio_ready), 64'd0);
    end
    @(posedge clk); #1;
    reset = 1'b1;
    release_slot(10);
    stat_rd(0, 32'd0, "rst_errcnt");
    stat_rd(1, 32'd0, "rst_last");
    stat_rd(2, 32'd0, "rst_acc");
    issue(1'b0, 2, 0, 32'h0, 32'h0000_00A5, 1'b0, 2, "rd_s2_after_rst");
    wait_done("rd_s2_after_rst");

    repeat (3) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/mmio_wait_controller.md
Name: mmio_wait_controller

Overview:
- Parametrised MMIO slot controller for the FPro bus: decodes bus accesses into N_SLOT slots with per-slot chip-select, read/write strobes and register address.
- Adds a per-slot ready/wait handshake with timeout.
- Returns a bus error for unpopulated or timed-out slots.
- Exposes a built-in status slot holding error and access statistics.
- Sits between the processor MMIO bus and the slot cores in mmio subsystems, replacing the fixed 64-slot zero-wait controller.

Parameters:
- N_SLOT, 64: number of slots; power of 2, 4..64; SW = clog2(N_SLOT).
- REG_AW, 5: register address bits per slot.
- SLOT_MASK, 64'h0000_0000_0000_050F: bit i = 1 means slot i is populated; bits at or above N_SLOT are ignored.
- TIMEOUT, 16: maximum wait cycles after the strobe; range 1..255.
- STAT_SLOT, N_SLOT-1: slot index served internally as the status block; overrides SLOT_MASK.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- mmio_cs  in  1  bus access request.
- mmio_wr  in  1  write request, qualified by mmio_cs.
- mmio_rd  in  1  read request, qualified by mmio_cs.
- mmio_addr  in  21  word address; bits [REG_AW+SW-1:0] used: slot = [REG_AW+:SW], reg = [REG_AW-1:0].
- mmio_wr_data  in  32  write data.
- mmio_rd_data  out  32  registered read data.
- mmio_ready  out  1  one-cycle completion pulse.
- mmio_err  out  1  error flag, valid with mmio_ready.
- slot_cs_array  out  N_SLOT  one-hot slot select, one-cycle.
- slot_mem_rd_array  out  N_SLOT  one-hot read strobe.
- slot_mem_wr_array  out  N_SLOT  one-hot write strobe.
- slot_reg_addr  out  REG_AW  latched register address, broadcast to all slots.
- slot_wr_data  out  32  latched write data, broadcast to all slots.
- slot_rd_data_flat  in  N_SLOT*32  slot i read data in bits [32i+:32].
- slot_ready_array  in  N_SLOT  slot i completion; tie high for zero-wait cores.

Behaviour:
- Reset (reset=0, asynchronous): all outputs 0, FSM IDLE, all counters and registers 0. Assertion mid-transaction drops strobes immediately; no mmio_ready is issued for the aborted access.
- FSM states: IDLE, ACCESS, WAIT, DONE.
- IDLE: on mmio_cs & (mmio_rd | mmio_wr), latch slot, reg, wr_data and op. If mmio_rd and mmio_wr are both high, the operation is a write.
  - Target is STAT_SLOT: go to DONE; internal register accessed at the transition.
  - Target is unpopulated: go to DONE with err=1; no strobe; error logged as type 0.
  - Otherwise: go to ACCESS.
- ACCESS (one cycle): slot_cs_array[slot], and the matching rd or wr strobe, are high. The timeout counter is cleared. If slot_ready_array[slot]=1, capture read data and go to DONE; else go to WAIT.
- WAIT: strobes low; slot_reg_addr and slot_wr_data held stable.
  - Each cycle without ready, the counter increments.
  - slot_ready high: capture slot_rd_data_flat[slot], go to DONE.
  - Counter reaches TIMEOUT with no ready: err=1, error logged as type 1, go to DONE.
  - If ready and timeout coincide, ready wins.
- DONE (one cycle): mmio_ready=1 and mmio_err valid, then return to IDLE.
  - Read: mmio_rd_data = captured data, or 32'hFFFF_FFFF on error.
  - Write: mmio_rd_data = 0.
  - mmio_rd_data holds its value until the next DONE.
- Latency from request cycle to mmio_ready:
  - status slot or unpopulated slot: 1 cycle;
  - zero-wait slot: 2 cycles;
  - slot with k wait cycles: 2+k;
  - timeout: 2+TIMEOUT.
- Requests while not IDLE are ignored and not queued. The master must wait for mmio_ready.
- Status slot registers:
  - reg 0, read: error_cnt, 16-bit, saturating at 16'hFFFF, zero-extended. Any write clears error_cnt and reg 1.
  - reg 1, read: {23'b0, type[8], slot[7:2] zero-extended, reg[1:0]}. Holds the last error: type, slot, and the low 2 bits of reg. Read-only.
  - reg 2, read: access_cnt, 32-bit wrapping counter of completed accesses to non-status slots, including errors. Any write clears it.
  - Other regs: read 0, writes ignored.
  - Status accesses never set mmio_err.
- A clear write and a counter increment cannot coincide, because accesses are serialized.

Test Plan:
- Read slot 2 (mask bit set, ready tied 1, data 32'h0000_00A5), addr = {slot 2, reg 0}: strobe in cycle 1, mmio_ready in cycle 2, rd_data 32'h0000_00A5, err 0.
- Write 32'h1234_5678 to slot 8 reg 3, slot ready after 3 wait cycles: single-cycle wr strobe, slot_wr_data=32'h1234_5678 and slot_reg_addr=3 held throughout, mmio_ready at cycle 5, err 0.
- Read slot 5 (unpopulated): no strobe, mmio_ready at cycle 1, rd_data 32'hFFFF_FFFF, err 1; status reg 0 reads 1, reg 1 type=0, slot=5.
- Read slot 10 with ready held low, TIMEOUT=16: mmio_ready at cycle 18, rd_data 32'hFFFF_FFFF, err 1; reg 1 type=1, slot=10; ready arriving exactly at cycle 17 yields valid data with err 0.
- Issue 3 accesses, then write status reg 2: reg 2 reads 3 before the write and 0 after; a second mmio_cs pulse during WAIT is ignored (access_cnt increments only once).
- Assert reset during WAIT: strobes and mmio_ready stay 0, FSM returns to IDLE, counters read 0 after release, and the next read completes normally.
